// File: rtl/dram_ctrl_pkg.sv
// Shared types and constants for the distributed-RAM write scheduler.
// A word is eight 2-bit lanes, matching the RAM32M16 DIA..DIH inputs.
package dram_ctrl_pkg;

  typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;

  localparam int RAM_ADDR_W = 5;
  localparam int DEPTH      = 2 ** RAM_ADDR_W;
  localparam int LANES      = 8;
  localparam int LANE_W     = 2;
  localparam int WORD_W     = LANES * LANE_W;

  function automatic logic [LANE_W-1:0] lane(input logic [WORD_W-1:0] word, input int n);
    return word[n*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/dram_wr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr,
// wrapping modulo N. No grant at all when en is low.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  localparam int SW = PW + 1;

  logic          found;
  logic [SW-1:0] sum;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      idx = sum[PW-1:0];
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_wr_sched.sv
// Write-port scheduler for a RAM32M16-style RAM: initialisation sweep after reset
// or clear, then round-robin arbitration of NUM_REQ writers onto one write port.
module dram_wr_sched
  import dram_ctrl_pkg::*;
#(
  parameter int                NUM_REQ    = 4,
  parameter int                ADDR_W     = 5,
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] INIT_VALUE = 16'h0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_waddr,
  output logic [DATA_W-1:0]         ram_wdata,
  output logic                      init_done,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   sweep_addr_reg;
  logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic                ram_we_reg;
  logic [ADDR_W-1:0]   ram_waddr_reg;
  logic [DATA_W-1:0]   ram_wdata_reg;

  logic [NUM_REQ-1:0]  gnt;
  logic [PTR_W-1:0]    gnt_idx;
  logic                transfer;
  logic                arb_en;

  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // clear pre-empts every request in the cycle it is seen
  assign arb_en = (state_reg == ST_RUN) && !clear;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_reg),
    .en  (arb_en),
    .gnt (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = PTR_W'(i);
    end
    transfer    = |gnt;
    rr_ptr_next = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_INIT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT: if (&sweep_addr_reg) state_next = ST_RUN;
      ST_RUN:  if (clear)           state_next = ST_INIT;
      default:                      state_next = ST_INIT;
    endcase
  end

  always_comb begin
    req_ready = gnt;
    init_done = (state_reg == ST_RUN);
    busy      = (state_reg == ST_INIT) || ram_we_reg;
  end

  // Write-port registers; address/data hold when no beat is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_addr_reg <= '0;
      rr_ptr_reg     <= '0;
      ram_we_reg     <= 1'b0;
      ram_waddr_reg  <= '0;
      ram_wdata_reg  <= '0;
    end else if (state_reg == ST_INIT) begin
      ram_we_reg     <= 1'b1;
      ram_waddr_reg  <= sweep_addr_reg;
      ram_wdata_reg  <= INIT_VALUE;
      sweep_addr_reg <= sweep_addr_reg + ADDR_W'(1);
    end else if (clear) begin
      ram_we_reg     <= 1'b0;
      sweep_addr_reg <= '0;
    end else if (transfer) begin
      ram_we_reg     <= 1'b1;
      ram_waddr_reg  <= addr_arr[gnt_idx];
      ram_wdata_reg  <= data_arr[gnt_idx];
      rr_ptr_reg     <= rr_ptr_next;
    end else begin
      ram_we_reg     <= 1'b0;
    end
  end

  assign ram_we    = ram_we_reg;
  assign ram_waddr = ram_waddr_reg;
  assign ram_wdata = ram_wdata_reg;

endmodule

// File: tb/tb_dram_wr_sched.sv
// Bench for dram_wr_sched: directed scenarios plus randomized traffic checked each
// cycle against a behavioural model of the sweep, grant order and RAM contents.
module tb_dram_wr_sched;
  import dram_ctrl_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 5;
  localparam int DW  = 16;
  localparam int DEP = 32;

  logic            clk = 1'b0;
  logic            rst, clear;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            ram_we;
  logic [AW-1:0]   ram_waddr;
  logic [DW-1:0]   ram_wdata;
  logic            init_done, busy;

  dram_wr_sched #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .INIT_VALUE(16'h0000)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the RAM primitive so written words can be read back
  logic [DW-1:0] tb_ram [DEP];
  always @(posedge clk) if (ram_we === 1'b1) tb_ram[ram_waddr] <= ram_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  // Behavioural model: sweep position, fairness pointer, pending write, RAM image
  bit            m_ok = 1'b0;
  bit            m_init;
  int            m_pos, m_ptr;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_mem [DEP];

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  initial forever begin
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    g       = -1;
    exp_rdy = '0;
    if (m_ok) begin
      if (!m_init && !clear) g = pick(req_valid, m_ptr);
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("cyc_ready", req_ready, exp_rdy);
      chk("cyc_we", ram_we, m_we);
      chk("cyc_waddr", ram_waddr, m_addr);
      chk("cyc_wdata", ram_wdata, m_data);
      chk("cyc_init_done", init_done, !m_init);
      chk("cyc_busy", busy, m_init || m_we);
      if (m_we) m_mem[m_addr] = m_data;
    end
    if (rst) begin
      m_ok = 1'b1; m_init = 1'b1; m_pos = 0; m_ptr = 0;
      m_we = 1'b0; m_addr = '0; m_data = '0;
    end else if (m_ok) begin
      if (m_init) begin
        m_we = 1'b1; m_addr = AW'(m_pos); m_data = 16'h0000;
        m_pos++;
        if (m_pos == DEP) m_init = 1'b0;
      end else if (clear) begin
        m_we = 1'b0; m_init = 1'b1; m_pos = 0;
      end else if (g >= 0) begin
        m_we   = 1'b1;
        m_addr = req_addr[g*AW +: AW];
        m_data = req_data[g*DW +: DW];
        m_ptr  = (g + 1) % N;
      end else begin
        m_we = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    tick(); tick();
    chk("rst_we", ram_we, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 1);
    rst = 1'b0;

    // Sweep after reset, requests held high to prove they are ignored
    tick();
    for (int i = 0; i < DEP; i++) begin
      req_valid = (i < DEP - 1) ? '1 : '0;
      #1;
      chk("sweep_we", ram_we, 1);
      chk("sweep_addr", ram_waddr, i);
      chk("sweep_data", ram_wdata, 16'h0000);
      chk("sweep_ready", req_ready, 0);
      chk("sweep_init_done", init_done, (i == DEP - 1));
      tick();
    end
    req_valid = '0;
    #1 chk("post_sweep_we", ram_we, 0);

    // Single requester 2
    set_req(2, 1'b1, 5'd7, 16'hA5C3);
    #1 chk("single_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    #1;
    chk("single_we", ram_we, 1);
    chk("single_addr", ram_waddr, 7);
    chk("single_data", ram_wdata, 16'hA5C3);
    tick();
    chk("single_readback", tb_ram[7], 16'hA5C3);
    chk("model_mem7", m_mem[7], 16'hA5C3);
    chk("single_lane7", lane(tb_ram[7], 7), 2'b10);
    chk("single_idle_we", ram_we, 0);

    // Bring the pointer back to 0, then all four requesters back-to-back
    set_req(3, 1'b1, 5'd0, 16'h0000);
    #1 chk("align_ready", req_ready, 4'b1000);
    tick();
    for (int r = 0; r < N; r++) set_req(r, 1'b1, AW'(8 + r), DW'(16'hB000 + r));
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_ready", req_ready, 4'b0001 << (k % N));
      chk("rr_we", ram_we, 1);
      if (k > 0) chk("rr_addr", ram_waddr, 8 + ((k - 1) % N));
      tick();
    end
    req_valid = '0;
    #1 chk("rr_last_we", ram_we, 1);
    chk("rr_last_addr", ram_waddr, 11);
    tick();

    // clear with requester 1 waiting
    set_req(1, 1'b1, 5'd3, 16'h0777);
    clear = 1'b1;
    #1 chk("clear_ready", req_ready, 0);
    tick();
    clear = 1'b0;
    #1 chk("clear_we", ram_we, 0);
    chk("clear_init_done", init_done, 0);
    for (int i = 0; i < DEP; i++) begin
      tick();
      chk("resweep_addr", ram_waddr, i);
      chk("resweep_ready", req_ready, (i == DEP - 1) ? 4'b0010 : 4'b0000);
    end
    tick();
    req_valid = '0;
    #1 chk("after_clear_addr", ram_waddr, 3);
    chk("after_clear_data", ram_wdata, 16'h0777);
    tick();

    // Reset in the middle of a sweep
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("mid_sweep_addr", ram_waddr, 13);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("rst_mid_we", ram_we, 0);
    chk("rst_mid_addr", ram_waddr, 0);
    for (int i = 0; i < DEP; i++) begin
      tick();
      chk("restart_addr", ram_waddr, i);
      chk("restart_we", ram_we, 1);
    end
    chk("restart_done", init_done, 1);
    tick();

    // Same address from requesters 0 then 3
    set_req(0, 1'b1, 5'd4, 16'h1111);
    set_req(3, 1'b1, 5'd4, 16'h3333);
    #1 chk("order_ready0", req_ready, 4'b0001);
    tick();
    chk("order_ready3", req_ready, 4'b1000);
    chk("order_data0", ram_wdata, 16'h1111);
    tick();
    req_valid = '0;
    #1 chk("order_data3", ram_wdata, 16'h3333);
    tick();
    chk("order_readback", tb_ram[4], 16'h3333);
    chk("model_mem4", m_mem[4], 16'h3333);

    // Randomized traffic with occasional clear and reset
    for (int c = 0; c < 600; c++) begin
      req_valid = (c % 2 == 0) ? N'($urandom) : N'($urandom & $urandom);
      req_addr  = (N*AW)'($urandom);
      req_data  = {$urandom, $urandom};
      clear     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; clear = 1'b0; req_valid = '0;
    repeat (40) tick();
    for (int a = 0; a < DEP; a++) chk("final_mem", tb_ram[a], m_mem[a]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
